// File: rtl/pipe_hazard_ctrl_if.sv
// S1 instruction, configuration and hazard-control signals shared between the
// decode stage (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
  logic        s1_valid;
  logic [4:0]  s1_rs;
  logic [4:0]  s1_rt;
  logic        s1_uses_rt;
  logic        s1_we;
  logic [4:0]  s1_ws;
  logic        cfg_wr;
  logic        cfg_fwd;
  logic        stall;
  logic        bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] retire_cnt;
  logic [15:0] stall_cnt;

  modport master (
    output s1_valid, s1_rs, s1_rt, s1_uses_rt, s1_we, s1_ws, cfg_wr, cfg_fwd,
    input  stall, bubble, fwd_a, fwd_b, retire_cnt, stall_cnt
  );

  modport slave (
    input  s1_valid, s1_rs, s1_rt, s1_uses_rt, s1_we, s1_ws, cfg_wr, cfg_fwd,
    output stall, bubble, fwd_a, fwd_b, retire_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Data-hazard controller for a 3-stage pipeline: tracks the writers in S2/S3 and
// either forwards their results to S1 or stalls S1 until the hazard drains.
module pipe_hazard_ctrl #(
  parameter bit FWD_DEFAULT = 1'b1
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] ws;
  } trk_t;

  trk_t        t2_reg, t3_reg, t2_next;
  trk_t        trk [2];
  logic        fwd_en_reg;
  logic [15:0] retire_cnt_reg, stall_cnt_reg;

  logic [1:0]  live, hit_a, hit_b;
  logic        stall_int;
  logic [1:0]  fwd_a_int, fwd_b_int;

  // Entry 0 is the youngest (S2) so it wins the forwarding priority below.
  assign trk[0] = t2_reg;
  assign trk[1] = t3_reg;

  // Hits are masked during reset so S1 never sees stale tracker contents.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_trk
      assign live[gi]  = trk[gi].valid & trk[gi].we & (trk[gi].ws != 5'd0);
      assign hit_a[gi] = live[gi] & bus.s1_valid & ~rst & (trk[gi].ws == bus.s1_rs);
      assign hit_b[gi] = live[gi] & bus.s1_valid & ~rst & bus.s1_uses_rt
                         & (trk[gi].ws == bus.s1_rt);
    end
  endgenerate

  function automatic logic [1:0] fwd_sel(input logic [1:0] hits);
    if (hits[0])      return 2'b01;
    else if (hits[1]) return 2'b10;
    else              return 2'b00;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_int = 1'b0;
    fwd_a_int = 2'b00;
    fwd_b_int = 2'b00;
    if (fwd_en_reg) begin
      fwd_a_int = fwd_sel(hit_a);
      fwd_b_int = fwd_sel(hit_b);
    end else begin
      stall_int = (|hit_a) | (|hit_b);
    end
  end

  // A stalled S1 instruction is replaced by a bubble entering S2.
  always_comb begin
    t2_next       = '0;
    t2_next.valid = bus.s1_valid & ~stall_int;
    t2_next.we    = bus.s1_we;
    t2_next.ws    = bus.s1_ws;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t2_reg         <= '0;
      t3_reg         <= '0;
      fwd_en_reg     <= FWD_DEFAULT;
      retire_cnt_reg <= 16'd0;
      stall_cnt_reg  <= 16'd0;
    end else begin
      t3_reg <= t2_reg;
      t2_reg <= t2_next;
      if (bus.cfg_wr)
        fwd_en_reg <= bus.cfg_fwd;
      if (t3_reg.valid)
        retire_cnt_reg <= sat_inc(retire_cnt_reg);
      if (stall_int)
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
    end
  end

  assign bus.stall      = stall_int;
  assign bus.bubble     = stall_int;
  assign bus.fwd_a      = fwd_a_int;
  assign bus.fwd_b      = fwd_b_int;
  assign bus.retire_cnt = retire_cnt_reg;
  assign bus.stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: forwarding, stall mode, r0,
// immediate operands, priority, reset mid-stall and counter saturation.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.FWD_DEFAULT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic we, input logic [4:0] ws);
    bus.s1_valid   = v;
    bus.s1_rs      = rs;
    bus.s1_rt      = rt;
    bus.s1_uses_rt = ut;
    bus.s1_we      = we;
    bus.s1_ws      = ws;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_mode(input logic fwd);
    drive(0, 0, 0, 0, 0, 0);
    bus.cfg_wr  = 1'b1;
    bus.cfg_fwd = fwd;
    tick();
    bus.cfg_wr  = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.cfg_wr  = 1'b0;
    bus.cfg_fwd = 1'b0;
    drive(1, 3, 3, 1, 1, 3);

    // Reset: outputs quiet even with a matching S1 instruction present
    tick();
    check("rst_stall", bus.stall, 0);
    check("rst_fwd_a", bus.fwd_a, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_retire", bus.retire_cnt, 0);
    check("post_rst_stallcnt", bus.stall_cnt, 0);
    check("post_rst_stall", bus.stall, 0);
    check("post_rst_fwd_b", bus.fwd_b, 0);

    // Forwarding mode: S2 then S3 source for r3
    drive(1, 1, 2, 1, 1, 3);
    #1;
    check("fwd_writer_stall", bus.stall, 0);
    tick();
    drive(1, 3, 0, 1, 0, 0);
    #1;
    check("fwd_s2_a", bus.fwd_a, 1);
    check("fwd_s2_stall", bus.stall, 0);
    check("fwd_s2_b_r0", bus.fwd_b, 0);
    tick();
    #1;
    check("fwd_s3_a", bus.fwd_a, 2);
    idle(2);

    // Stall mode: r5 hazard stalls exactly two cycles
    set_mode(0);
    drive(1, 0, 0, 0, 1, 5);
    tick();
    drive(1, 5, 5, 1, 0, 0);
    #1;
    check("stl_c1_stall", bus.stall, 1);
    check("stl_c1_bubble", bus.bubble, 1);
    check("stl_c1_fwd_a", bus.fwd_a, 0);
    tick();
    check("stl_c2_stall", bus.stall, 1);
    tick();
    check("stl_c3_stall", bus.stall, 0);
    check("stl_cnt", bus.stall_cnt, 2);
    idle(2);

    // r0 never hazards, in both modes
    drive(1, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0);
    #1;
    check("r0_stlmode_stall", bus.stall, 0);
    check("r0_stlmode_fwd_a", bus.fwd_a, 0);
    set_mode(1);
    drive(1, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 1, 0, 0);
    #1;
    check("r0_fwdmode_fwd_a", bus.fwd_a, 0);
    check("r0_fwdmode_stall", bus.stall, 0);

    // Immediate operand ignores rt; s1_valid=0 silences everything
    drive(1, 1, 1, 0, 1, 7);
    tick();
    drive(1, 1, 7, 0, 0, 0);
    #1;
    check("imm_fwd_b", bus.fwd_b, 0);
    check("imm_stall", bus.stall, 0);
    bus.s1_uses_rt = 1'b1;
    #1;
    check("reg_fwd_b", bus.fwd_b, 1);
    check("reg_fwd_a", bus.fwd_a, 0);
    bus.s1_valid = 1'b0;
    #1;
    check("novalid_fwd_b", bus.fwd_b, 0);

    // Two in-flight writers to r4: youngest (S2) wins
    drive(1, 0, 0, 0, 1, 4);
    tick();
    drive(1, 0, 0, 0, 1, 4);
    tick();
    drive(1, 4, 0, 0, 0, 0);
    #1;
    check("prio_fwd_a", bus.fwd_a, 1);
    idle(3);

    // Mode write during a stall: current cycle still stalls, tracker keeps r9
    set_mode(0);
    drive(1, 0, 0, 0, 1, 9);
    tick();
    drive(1, 9, 0, 0, 0, 0);
    bus.cfg_wr  = 1'b1;
    bus.cfg_fwd = 1'b1;
    #1;
    check("cfgmid_stall", bus.stall, 1);
    tick();
    bus.cfg_wr = 1'b0;
    #1;
    check("cfgmid_next_stall", bus.stall, 0);
    check("cfgmid_next_fwd_a", bus.fwd_a, 2);
    check("cfgmid_stallcnt", bus.stall_cnt, 3);
    idle(3);

    // Reset in the middle of a stall
    set_mode(0);
    drive(1, 0, 0, 0, 1, 9);
    tick();
    drive(1, 9, 0, 0, 0, 0);
    #1;
    check("rstmid_pre_stall", bus.stall, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rstmid_during_stall", bus.stall, 0);
    check("rstmid_during_bubble", bus.bubble, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_after_stall", bus.stall, 0);
    check("rstmid_after_fwd_a", bus.fwd_a, 0);
    check("rstmid_after_stallcnt", bus.stall_cnt, 0);
    check("rstmid_after_retire", bus.retire_cnt, 0);
    drive(1, 0, 0, 0, 1, 9);
    tick();
    drive(1, 9, 0, 0, 0, 0);
    #1;
    check("rstmid_default_fwd_a", bus.fwd_a, 1);
    check("rstmid_default_stall", bus.stall, 0);
    set_mode(0);
    drive(1, 0, 0, 0, 1, 9);
    tick();
    drive(1, 9, 0, 0, 0, 0);
    #1;
    check("rstmid_stlmode_stall", bus.stall, 1);
    idle(3);

    // Retire counting and saturation
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    #1;
    check("ret_start", bus.retire_cnt, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    idle(3);
    check("ret_three", bus.retire_cnt, 3);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) tick();
    idle(3);
    check("ret_saturate", bus.retire_cnt, 16'hFFFF);
    check("ret_sat_stallcnt", bus.stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Reset: rst, synchronous, active-high. Clock: clk. Both are already decided.
REQ-002 Parameter FWD_DEFAULT, default 1, sets the value of fwd_en after reset.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 s1_valid  in  1  a valid instruction is present in S1 (decode/RF read).
REQ-006 s1_rs  in  5  source register A of the S1 instruction.
REQ-007 s1_rt  in  5  source register B of the S1 instruction.
REQ-008 s1_uses_rt  in  1  0 = immediate operand (DataSource=1), so rt is ignored.
REQ-009 s1_we  in  1  the S1 instruction writes the register file.
REQ-010 s1_ws  in  5  destination register of the S1 instruction.
REQ-011 cfg_wr  in  1  when high, load cfg_fwd into fwd_en.
REQ-012 cfg_fwd  in  1  new forwarding-enable value.
REQ-013 stall  out  1  hold the PC and S1; combinational from tracker state and S1 inputs.
REQ-014 bubble  out  1  force the S2 register's WriteEnable to 0 this edge; equals stall.
REQ-015 fwd_a  out  2  operand A source select: 00 = RF, 01 = S2 ALU result, 10 = S3 writeback data.
REQ-016 fwd_b  out  2  operand B source select, same encoding as fwd_a.
REQ-017 retire_cnt  out  16  count of instructions leaving S3.
REQ-018 stall_cnt  out  16  count of stall cycles.

Function
REQ-019 The block keeps two tracker entries, T2 (S2) and T3 (S3), each holding {valid, we, ws}.
REQ-020 An entry is live when valid=1, we=1 and ws!=0; register 0 never creates a hazard.
REQ-021 A match on A: a live entry has ws==s1_rs and s1_valid=1.
REQ-022 A match on B: additionally requires s1_uses_rt=1 and ws==s1_rt.
REQ-023 With fwd_en=1: stall=0; fwd_x=01 on a T2 match, else 10 on a T3 match, else 00; T2 takes priority over T3.
REQ-024 With fwd_en=0: stall=1 on any A or B match with T2 or T3; fwd_a=fwd_b=00.
REQ-025 Every edge (not in reset): T3<=T2.
REQ-026 Every edge (not in reset): T2<={s1_valid & ~stall, s1_we, s1_ws}, so a stall inserts a bubble.
REQ-027 The maximum consecutive stall run is 2 cycles, since the hazard drains from T2 to T3 and then out.
REQ-028 retire_cnt increments when T3.valid=1 at an edge.
REQ-029 stall_cnt increments when stall=1 at an edge.
REQ-030 Both counters saturate at 0xFFFF and do not wrap.
REQ-031 On cfg_wr=1, fwd_en takes cfg_fwd at the edge and the new mode applies from the next cycle.
REQ-032 A cfg_wr mid-stall does not alter tracker contents.
REQ-033 When s1_valid=0: stall=0 and fwd_a=fwd_b=00.
REQ-034 If a T2 and a T3 entry target the same register, the T2 (youngest) entry governs forwarding.

Reset
REQ-035 rst=1 at an edge clears T2 and T3 to {0,0,0}, clears retire_cnt and stall_cnt to 0, and sets fwd_en=FWD_DEFAULT.
REQ-036 Reset has priority over cfg_wr and over all tracker shifts.
REQ-037 During and immediately after reset, stall=0 and fwd_a=fwd_b=00 regardless of S1 inputs, because trackers are empty.
REQ-038 A reset asserted mid-stall discards the in-flight bubble and entries; no retire is counted for that edge.

Verification
REQ-039 fwd_en=1; issue r3<-..., then next cycle rs=3 -> fwd_a=01, stall=0; one cycle later a rs=3 reader -> fwd_a=10.
REQ-040 fwd_en=0; issue r5 writer, then an rs=5,rt=5 reader -> stall=1 for 2 cycles, bubble=1, then stall=0; stall_cnt=2.
REQ-041 Writer to r0, then reader rs=0 -> stall=0, fwd_a=00 in both modes.
REQ-042 Immediate op (s1_uses_rt=0) with rt equal to an in-flight ws=7 -> fwd_b=00, no stall; with s1_uses_rt=1 -> fwd_b=01.
REQ-043 Back-to-back writers to r4 then a reader rs=4 -> fwd_a=01 (T2 priority); 70000 valid issues -> retire_cnt=0xFFFF.
REQ-044 rst asserted during a stall -> next cycle all outputs 0 and fwd_en=FWD_DEFAULT; cfg_wr=1 with cfg_fwd=0 then switches to stall mode.
